// File: rtl/bram_requester.sv
// Requester for a single-cycle-latency Bram: zero-fills every row after reset, then issues user reads
// and writes; read data lands in a small credit-managed response FIFO. Optional: BRAM_REQ_WR_FWD_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | writing zero to row init_ptr each cycle, user ports closed
// ST_RUN   | user writes pass straight through, reads issued on credit
module bram_requester #(
    parameter int dataSize  = 32,
    parameter int addrSize  = 9,
    parameter int numRows   = 512,
    parameter int respDepth = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                reqEnable,
    input  logic [addrSize-1:0] reqAddr,
    output logic                reqReady,
    output logic [dataSize-1:0] respData,
    output logic                respReady,
    input  logic                respEnable,
    input  logic                wrEnable,
    input  logic [addrSize-1:0] wrAddr,
    input  logic [dataSize-1:0] wrData,
    output logic                wrReady,
    output logic                initDone,
    output logic                memReadEnable,
    output logic [addrSize-1:0] memReadAddr,
    input  logic [dataSize-1:0] memReadData,
    output logic                memWriteEnable,
    output logic [addrSize-1:0] memWriteAddr,
    output logic [dataSize-1:0] memWriteData
);

    localparam int PW = (respDepth > 1) ? $clog2(respDepth) : 1;
    localparam int CW = $clog2(respDepth + 1) + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state, state_next;
    logic [addrSize-1:0] init_ptr;
    logic [dataSize-1:0] fifo_mem [respDepth];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_after;
    logic [CW-1:0]       credit;
    logic                in_flight;
    logic                run, issue, wr_acc, deq, enq;
    logic [dataSize-1:0] enq_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(respDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign run    = (state == ST_RUN);
    assign wr_acc = wrEnable && wrReady;
    assign deq    = respEnable && respReady;
    assign enq    = in_flight;
    assign issue  = reqEnable && reqReady;

    // A dequeue in this cycle frees its slot for a request in the same cycle.
    assign count_after = count - CW'(deq);
    assign credit      = count_after + CW'(in_flight);
    assign reqReady    = run && (credit < CW'(respDepth));

    assign respReady     = (count != '0);
    assign respData      = respReady ? fifo_mem[rd_ptr] : '0;
    assign memReadEnable = issue;
    assign memReadAddr   = run ? reqAddr : '0;
    assign initDone      = run;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= ST_INIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next     = state;
        wrReady        = 1'b0;
        memWriteEnable = 1'b0;
        memWriteAddr   = '0;
        memWriteData   = '0;
        case (state)
            ST_INIT: begin
                // Gated by RST_N so the zero-fill port stays quiet while reset is held.
                memWriteEnable = RST_N;
                memWriteAddr   = init_ptr;
                if (init_ptr == addrSize'(numRows - 1))
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                wrReady        = 1'b1;
                memWriteEnable = wrEnable;
                memWriteAddr   = wrAddr;
                memWriteData   = wrData;
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_ptr  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_flight <= 1'b0;
        end else begin
            if (state == ST_INIT) init_ptr <= init_ptr + 1'b1;
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
            count     <= count + CW'(enq) - CW'(deq);
            in_flight <= issue;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq) fifo_mem[wr_ptr] <= enq_data;
    end

`ifdef BRAM_REQ_WR_FWD_EN
    logic                fwd_valid;
    logic [dataSize-1:0] fwd_data;

    // Same-cycle write and read to one row: the Bram returns the old word, so keep the new one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fwd_valid <= 1'b0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= issue && wr_acc && (wrAddr == reqAddr);
            if (issue && wr_acc && (wrAddr == reqAddr))
                fwd_data <= wrData;
        end
    end

    assign enq_data = fwd_valid ? fwd_data : memReadData;
`else
    logic unused_wr_acc;
    assign unused_wr_acc = wr_acc;
    assign enq_data      = memReadData;
`endif

endmodule

// File: tb/tb_bram_requester.sv
// Directed bench for bram_requester: zero-fill sequence, vector table for write/read/credit/same-row
// cases, a 100-read stream and a mid-operation reset. Bram is modelled here with 1-cycle read latency.
module tb_bram_requester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_enable;
    logic [8:0]  req_addr;
    logic        req_ready;
    logic [31:0] resp_data;
    logic        resp_ready;
    logic        resp_enable;
    logic        wr_enable;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        init_done;
    logic        mem_read_enable;
    logic [8:0]  mem_read_addr;
    logic [31:0] mem_read_data;
    logic        mem_write_enable;
    logic [8:0]  mem_write_addr;
    logic [31:0] mem_write_data;

    int checks   = 0;
    int failures = 0;

`ifdef BRAM_REQ_WR_FWD_EN
    localparam logic [31:0] SAME_ROW_EXP = 32'h0000_1234;
`else
    localparam logic [31:0] SAME_ROW_EXP = 32'h0000_0000;
`endif

    always #5 clk = ~clk;

    bram_requester dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .reqEnable      (req_enable),
        .reqAddr        (req_addr),
        .reqReady       (req_ready),
        .respData       (resp_data),
        .respReady      (resp_ready),
        .respEnable     (resp_enable),
        .wrEnable       (wr_enable),
        .wrAddr         (wr_addr),
        .wrData         (wr_data),
        .wrReady        (wr_ready),
        .initDone       (init_done),
        .memReadEnable  (mem_read_enable),
        .memReadAddr    (mem_read_addr),
        .memReadData    (mem_read_data),
        .memWriteEnable (mem_write_enable),
        .memWriteAddr   (mem_write_addr),
        .memWriteData   (mem_write_data)
    );

    logic [31:0] bram [512];
    always @(posedge clk) begin
        if (mem_read_enable)  mem_read_data <= bram[mem_read_addr];
        if (mem_write_enable) bram[mem_write_addr] <= mem_write_data;
    end

    typedef struct {
        logic        req_en;
        logic [8:0]  req_addr;
        logic        resp_en;
        logic        wr_en;
        logic [8:0]  wr_addr;
        logic [31:0] wr_data;
        logic        x_req_ready;
        logic        x_resp_ready;
        logic [31:0] x_resp_data;
        logic        x_mem_re;
        logic        x_mem_we;
    } vec_t;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_enable  = 1'b0;
        req_addr    = '0;
        resp_enable = 1'b0;
        wr_enable   = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
    endtask

    // Called at the drive point right after RST_N rises; returns at the negedge where initDone must be 1.
    task automatic check_init(input string tag);
        int bad_rows  = 0;
        int bad_ready = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            if (mem_write_enable !== 1'b1 || mem_write_addr !== 9'(i) || mem_write_data !== 32'h0)
                bad_rows++;
            if (req_ready !== 1'b0 || wr_ready !== 1'b0 || init_done !== 1'b0)
                bad_ready++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk({tag, "_rows_bad"},  32'(bad_rows),  32'd0);
        chk({tag, "_ready_bad"}, 32'(bad_ready), 32'd0);
        chk({tag, "_init_done"}, {31'b0, init_done}, 32'd1);
        chk({tag, "_we_after"},  {31'b0, mem_write_enable}, 32'd0);
        chk({tag, "_wr_ready"},  {31'b0, wr_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           req  addr  resp  wr  waddr  wdata          rq_rdy rsp_rdy rsp_data        re    we
        vecs[0]  = '{1'b0, 9'd0, 1'b0, 1'b1, 9'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,          1'b0, 1'b1};
        vecs[1]  = '{1'b1, 9'd5, 1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b1, 1'b0};
        vecs[2]  = '{1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b0, 1'b0};
        vecs[3]  = '{1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF,   1'b0, 1'b0};
        vecs[4]  = '{1'b0, 9'd0, 1'b1, 1'b0, 9'd0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF,   1'b0, 1'b0};
        vecs[5]  = '{1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b0, 1'b0};
        vecs[6]  = '{1'b0, 9'd0, 1'b0, 1'b1, 9'd1, 32'h11,       1'b1, 1'b0, 32'h0,          1'b0, 1'b1};
        vecs[7]  = '{1'b0, 9'd0, 1'b0, 1'b1, 9'd2, 32'h22,       1'b1, 1'b0, 32'h0,          1'b0, 1'b1};
        vecs[8]  = '{1'b0, 9'd0, 1'b0, 1'b1, 9'd3, 32'h33,       1'b1, 1'b0, 32'h0,          1'b0, 1'b1};
        vecs[9]  = '{1'b1, 9'd1, 1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b1, 1'b0};
        vecs[10] = '{1'b1, 9'd2, 1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b1, 1'b0};
        vecs[11] = '{1'b1, 9'd3, 1'b0, 1'b0, 9'd0, 32'h0,        1'b0, 1'b1, 32'h11,         1'b0, 1'b0};
        vecs[12] = '{1'b1, 9'd3, 1'b0, 1'b0, 9'd0, 32'h0,        1'b0, 1'b1, 32'h11,         1'b0, 1'b0};
        vecs[13] = '{1'b1, 9'd3, 1'b1, 1'b0, 9'd0, 32'h0,        1'b1, 1'b1, 32'h11,         1'b1, 1'b0};
        vecs[14] = '{1'b0, 9'd0, 1'b1, 1'b0, 9'd0, 32'h0,        1'b1, 1'b1, 32'h22,         1'b0, 1'b0};
        vecs[15] = '{1'b0, 9'd0, 1'b1, 1'b0, 9'd0, 32'h0,        1'b1, 1'b1, 32'h33,         1'b0, 1'b0};
        vecs[16] = '{1'b0, 9'd0, 1'b1, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b0, 1'b0};
        vecs[17] = '{1'b1, 9'd7, 1'b0, 1'b1, 9'd7, 32'h1234,     1'b1, 1'b0, 32'h0,          1'b1, 1'b1};
        vecs[18] = '{1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b0, 1'b0};
        vecs[19] = '{1'b0, 9'd0, 1'b1, 1'b0, 9'd0, 32'h0,        1'b1, 1'b1, SAME_ROW_EXP,   1'b0, 1'b0};
        vecs[20] = '{1'b0, 9'd0, 1'b0, 1'b0, 9'd0, 32'h0,        1'b1, 1'b0, 32'h0,          1'b0, 1'b0};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_ready", {31'b0, resp_ready}, 32'd0);
        chk("rst_req_ready",  {31'b0, req_ready},  32'd0);
        chk("rst_wr_ready",   {31'b0, wr_ready},   32'd0);
        chk("rst_init_done",  {31'b0, init_done},  32'd0);
        chk("rst_mem_we",     {31'b0, mem_write_enable}, 32'd0);
        chk("rst_mem_re",     {31'b0, mem_read_enable},  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_init("init");

        @(posedge clk);
        #1;
        for (int i = 0; i < 21; i++) begin
            req_enable  = vecs[i].req_en;
            req_addr    = vecs[i].req_addr;
            resp_enable = vecs[i].resp_en;
            wr_enable   = vecs[i].wr_en;
            wr_addr     = vecs[i].wr_addr;
            wr_data     = vecs[i].wr_data;
            @(negedge clk);
            chk($sformatf("v%0d_req_ready", i),  {31'b0, req_ready},  {31'b0, vecs[i].x_req_ready});
            chk($sformatf("v%0d_resp_ready", i), {31'b0, resp_ready}, {31'b0, vecs[i].x_resp_ready});
            chk($sformatf("v%0d_resp_data", i),  resp_data,           vecs[i].x_resp_data);
            chk($sformatf("v%0d_mem_re", i),     {31'b0, mem_read_enable},  {31'b0, vecs[i].x_mem_re});
            chk($sformatf("v%0d_mem_we", i),     {31'b0, mem_write_enable}, {31'b0, vecs[i].x_mem_we});
            @(posedge clk);
            #1;
        end
        idle_inputs();

        for (int i = 0; i < 100; i++) begin
            wr_enable = 1'b1;
            wr_addr   = 9'(i);
            wr_data   = 32'h1000 + 32'(i);
            @(posedge clk);
            #1;
        end
        idle_inputs();

        for (int c = 0; c < 104; c++) begin
            req_enable  = (c < 100);
            req_addr    = 9'(c);
            resp_enable = 1'b1;
            @(negedge clk);
            if (c < 100)
                chk($sformatf("stream_req_ready_c%0d", c), {31'b0, req_ready}, 32'd1);
            chk($sformatf("stream_resp_ready_c%0d", c), {31'b0, resp_ready},
                {31'b0, (c >= 2 && c < 102)});
            if (c >= 2 && c < 102)
                chk($sformatf("stream_data_c%0d", c), resp_data, 32'h1000 + 32'(c - 2));
            @(posedge clk);
            #1;
        end
        idle_inputs();

        req_enable = 1'b1;
        req_addr   = 9'd10;
        @(posedge clk);
        #1;
        req_addr   = 9'd11;
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("pre_rst_resp_ready", {31'b0, resp_ready}, 32'd1);
        chk("pre_rst_req_ready",  {31'b0, req_ready},  32'd0);
        chk("pre_rst_resp_data",  resp_data,           32'h100A);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_resp_ready", {31'b0, resp_ready}, 32'd0);
        chk("mid_rst_resp_data",  resp_data,           32'd0);
        chk("mid_rst_init_done",  {31'b0, init_done},  32'd0);
        chk("mid_rst_mem_we",     {31'b0, mem_write_enable}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_init("reinit");
        @(negedge clk);
        chk("reinit_resp_ready", {31'b0, resp_ready}, 32'd0);
        chk("reinit_req_ready",  {31'b0, req_ready},  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
